fmul_share_arb: RTL

- Shares one FMUL32 instance among NUM_REQ requesters.
- Round-robin arbitration issues at most one operation per cycle into the fully pipelined multiplier.
- Carries a requester tag alongside each operation, matched to the FMUL latency, and returns each result to its requester.
- A halt/drain state machine lets the control plane quiesce the multiplier, e.g. before reconfiguring the rounding mode.

---
 rtl/fmul_share_arb_if.sv | 47 ++++
 rtl/fmul_share_arb.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fmul_share_arb_if.sv
`default_nettype none
// =============================================================================
// Module   : fmul_share_arb_if
// Brief    : Request, FMUL32 and response bundle for the shared-multiplier arbiter.
// Revision : 1.0  initial release
// =============================================================================
interface fmul_share_arb_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ*32-1:0]      req_op1;
    logic [NUM_REQ*32-1:0]      req_op2;
    logic [NUM_REQ*2-1:0]       req_opc;
    logic [NUM_REQ*2-1:0]       req_rmode;

    logic [31:0]                fm_op1;
    logic [31:0]                fm_op2;
    logic [1:0]                 fm_opc;
    logic [1:0]                 fm_r_mode;
    logic [31:0]                fm_result;
    logic                       fm_val;

    logic                       rsp_valid;
    logic [$clog2(NUM_REQ)-1:0] rsp_id;
    logic [31:0]                rsp_result;
    logic                       rsp_val;

    // Environment side: requesters plus the FMUL32 result path.
    modport master (
        output req_valid, req_op1, req_op2, req_opc, req_rmode,
        input  req_ready,
        input  fm_op1, fm_op2, fm_opc, fm_r_mode,
        output fm_result, fm_val,
        input  rsp_valid, rsp_id, rsp_result, rsp_val
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_op1, req_op2, req_opc, req_rmode,
        output req_ready,
        output fm_op1, fm_op2, fm_opc, fm_r_mode,
        input  fm_result, fm_val,
        output rsp_valid, rsp_id, rsp_result, rsp_val
    );
endinterface
`default_nettype wire

// File: rtl/fmul_share_arb.sv
`default_nettype none
// =============================================================================
// Module   : fmul_share_arb
// Brief    : Round-robin sharing of one pipelined FMUL32 with tag return and a
//            halt/drain FSM. Define FMUL_ARB_STATS_EN for issue/conflict counters.
// Revision : 1.0  initial release
// =============================================================================
module fmul_share_arb #(
    parameter int         NUM_REQ  = 4,
    parameter int         FMUL_LAT = 2,
    parameter logic [1:0] IDLE_OPC = 2'd3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   halt,
    fmul_share_arb_if.slave        bus,
    output logic                   busy,
    output logic                   halted
`ifdef FMUL_ARB_STATS_EN
    ,
    output logic [31:0]            issue_cnt,
    output logic [31:0]            conflict_cnt
`endif
);

    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t                         state_q;
    state_t                         state_d;
    logic [ID_W-1:0]                rr_ptr_q;
    logic [ID_W-1:0]                rr_ptr_d;
    logic [FMUL_LAT-1:0]            tag_vld_q;
    logic [FMUL_LAT-1:0][ID_W-1:0]  tag_id_q;
    logic                           rsp_valid_q;
    logic [ID_W-1:0]                rsp_id_q;
    logic [31:0]                    rsp_result_q;
    logic                           rsp_val_q;

    logic [31:0]                    w_op1   [NUM_REQ];
    logic [31:0]                    w_op2   [NUM_REQ];
    logic [1:0]                     w_opc   [NUM_REQ];
    logic [1:0]                     w_rmode [NUM_REQ];

    logic                           w_found;
    logic [ID_W-1:0]                w_win_id;
    logic [ID_W:0]                  w_idx_ext;
    logic [ID_W-1:0]                w_idx;
    logic                           w_grant;
    logic                           w_drained;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_op1[gi]   = bus.req_op1[32*gi +: 32];
        assign w_op2[gi]   = bus.req_op2[32*gi +: 32];
        assign w_opc[gi]   = bus.req_opc[2*gi +: 2];
        assign w_rmode[gi] = bus.req_rmode[2*gi +: 2];
    end

    // Search starts just past the last winner; the extra index bit absorbs the wrap.
    always_comb begin
        w_found   = 1'b0;
        w_win_id  = '0;
        w_idx_ext = '0;
        w_idx     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx_ext = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (w_idx_ext >= (ID_W+1)'(NUM_REQ)) begin
                w_idx_ext = w_idx_ext - (ID_W+1)'(NUM_REQ);
            end
            w_idx = w_idx_ext[ID_W-1:0];
            if (!w_found && bus.req_valid[w_idx]) begin
                w_found  = 1'b1;
                w_win_id = w_idx;
            end
        end
    end

    // halt gates grants in the same cycle it rises, before the FSM has moved.
    assign w_grant = w_found && (state_q == ST_RUN) && !halt;

    always_comb begin
        bus.req_ready = '0;
        if (w_grant) begin
            bus.req_ready[w_win_id] = 1'b1;
        end
    end

    always_comb begin
        bus.fm_op1    = 32'd0;
        bus.fm_op2    = 32'd0;
        bus.fm_opc    = IDLE_OPC;
        bus.fm_r_mode = 2'd0;
        if (w_grant) begin
            bus.fm_op1    = w_op1[w_win_id];
            bus.fm_op2    = w_op2[w_win_id];
            bus.fm_opc    = w_opc[w_win_id];
            bus.fm_r_mode = w_rmode[w_win_id];
        end
    end

    assign rr_ptr_d  = w_grant ? w_win_id : rr_ptr_q;
    assign w_drained = !(|tag_vld_q) && !rsp_valid_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (halt) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!halt)          state_d = ST_RUN;
                else if (w_drained) state_d = ST_HALTED;
            end
            ST_HALTED: begin
                if (!halt) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            rr_ptr_q     <= ID_W'(NUM_REQ-1);
            tag_vld_q    <= '0;
            tag_id_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= 32'd0;
            rsp_val_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            tag_vld_q[0] <= w_grant;
            tag_id_q[0]  <= w_win_id;
            for (int s = 1; s < FMUL_LAT; s++) begin
                tag_vld_q[s] <= tag_vld_q[s-1];
                tag_id_q[s]  <= tag_id_q[s-1];
            end
            // Last tag stage lines up with the FMUL32 output of the same operation.
            if (tag_vld_q[FMUL_LAT-1]) begin
                rsp_valid_q  <= 1'b1;
                rsp_id_q     <= tag_id_q[FMUL_LAT-1];
                rsp_result_q <= bus.fm_result;
                rsp_val_q    <= bus.fm_val;
            end else begin
                rsp_valid_q  <= 1'b0;
            end
        end
    end

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_val    = rsp_val_q;

    assign busy   = (|tag_vld_q) | rsp_valid_q;
    assign halted = (state_q == ST_HALTED);

`ifdef FMUL_ARB_STATS_EN
    logic [31:0] issue_cnt_q;
    logic [31:0] conflict_cnt_q;
    logic        w_multi;

    // Clearing the lowest set bit leaves something only when two or more are set.
    assign w_multi = |(bus.req_valid & (bus.req_valid - NUM_REQ'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt_q    <= 32'd0;
            conflict_cnt_q <= 32'd0;
        end else begin
            if (w_grant && (issue_cnt_q != 32'hFFFF_FFFF)) begin
                issue_cnt_q <= issue_cnt_q + 32'd1;
            end
            if (w_grant && w_multi && (conflict_cnt_q != 32'hFFFF_FFFF)) begin
                conflict_cnt_q <= conflict_cnt_q + 32'd1;
            end
        end
    end

    assign issue_cnt    = issue_cnt_q;
    assign conflict_cnt = conflict_cnt_q;
`endif

endmodule
`default_nettype wire
